// File: rtl/multi_counter_pkg.sv
// Shared definitions for the multi-channel counter with sample FIFO.
package multi_counter_pkg;

  localparam int unsigned MaxChW   = 4;
  localparam int unsigned MaxWidth = 32;

  // Channel index width: at least one bit even for a single channel.
  function automatic int unsigned ch_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic [MaxChW-1:0]   ch;
    logic [MaxWidth-1:0] count;
  } sample_t;

endpackage

// File: rtl/multi_counter_fifo_if.sv
// Sample FIFO output handshake: head data, valid/ready and full status.
interface multi_counter_fifo_if #(
  parameter int unsigned SW = 10
);
  logic [SW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          full_o;

  modport master (output data_o, output valid_o, output full_o, input ready_i);
  modport slave  (input data_o, input valid_o, input full_o, output ready_i);
endinterface

// File: rtl/mc_channel.sv
// One counter channel: wrapping add/subtract, load, running maximum, sticky wrap flag.
module mc_channel #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] delta_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic [WIDTH-1:0] max_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] r_cnt, r_max, w_cnt_d, w_max_d;
  logic             r_ovf, w_ovf_d;
  logic [WIDTH:0]   w_step;

  always_comb begin
    // Top bit of the widened result is the carry (add) or borrow (subtract).
    w_step  = down_i ? ({1'b0, r_cnt} - {1'b0, delta_i}) : ({1'b0, r_cnt} + {1'b0, delta_i});
    w_cnt_d = r_cnt;
    w_ovf_d = r_ovf;
    if (clear_i) begin
      w_cnt_d = '0;
      w_ovf_d = 1'b0;
    end else if (load_i) begin
      w_cnt_d = d_i;
    end else if (en_i) begin
      w_cnt_d = w_step[WIDTH-1:0];
      w_ovf_d = r_ovf | w_step[WIDTH];
    end
    w_max_d = r_max;
    if (clear_i) begin
      w_max_d = '0;
    end else if (w_cnt_d > r_max) begin
      w_max_d = w_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
      r_max <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_max <= w_max_d;
      r_ovf <= w_ovf_d;
    end
  end

  assign cnt_o = r_cnt;
  assign max_o = r_max;
  assign ovf_o = r_ovf;

endmodule

// File: rtl/multi_counter_fifo.sv
// NUM_CH counter channels with a sample FIFO that snapshots registered counts.
module multi_counter_fifo
  import multi_counter_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned CH_W   = ch_w(NUM_CH),
  localparam int unsigned SW     = CH_W + WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [NUM_CH-1:0]          en_i,
  input  logic [NUM_CH-1:0]          down_i,
  input  logic [WIDTH-1:0]           delta_i,
  input  logic                       load_i,
  input  logic [CH_W-1:0]            load_ch_i,
  input  logic [WIDTH-1:0]           d_i,
  input  logic [CH_W-1:0]            rd_ch_i,
  output logic [WIDTH-1:0]           q_o,
  output logic [WIDTH-1:0]           max_o,
  output logic [NUM_CH-1:0]          overflow_o,
  input  logic                       sample_i,
  input  logic [CH_W-1:0]            sample_ch_i,
  multi_counter_fifo_if.master       fifo_if,
  output logic [WIDTH-1:0]           drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] w_cnt [NUM_CH];
  logic [WIDTH-1:0] w_max [NUM_CH];
  logic [WIDTH-1:0] w_smp_cnt;
  logic             w_smp_ok;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mc_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clear_i(clear_i),
      .en_i   (en_i[c]),
      .down_i (down_i[c]),
      .delta_i(delta_i),
      .load_i (load_i && (load_ch_i == CH_W'(c))),
      .d_i    (d_i),
      .cnt_o  (w_cnt[c]),
      .max_o  (w_max[c]),
      .ovf_o  (overflow_o[c])
    );
  end

  // Out-of-range indices match no channel, so they read 0 and never push.
  always_comb begin
    q_o       = '0;
    max_o     = '0;
    w_smp_cnt = '0;
    w_smp_ok  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_i == CH_W'(i)) begin
        q_o   = w_cnt[i];
        max_o = w_max[i];
      end
      if (sample_ch_i == CH_W'(i)) begin
        w_smp_cnt = w_cnt[i];
        w_smp_ok  = 1'b1;
      end
    end
  end

  sample_t       w_entry;
  logic [SW-1:0] w_entry_bits;
  logic          w_unused_entry;

  assign w_entry        = '{ch: MaxChW'(sample_ch_i), count: MaxWidth'(w_smp_cnt)};
  assign w_entry_bits   = {w_entry.ch[CH_W-1:0], w_entry.count[WIDTH-1:0]};
  assign w_unused_entry = ^{w_entry.ch, w_entry.count};

  logic [SW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW:0]      r_usage;
  logic [WIDTH-1:0] r_drop;
  logic             w_valid, w_full, w_pop, w_push, w_drop;

  assign w_valid = (r_usage != '0);
  assign w_full  = (r_usage == (AW + 1)'(DEPTH));
  assign w_pop   = w_valid & fifo_if.ready_i & ~clear_i;
  assign w_push  = ~clear_i & sample_i & w_smp_ok & (~w_full | w_pop);
  assign w_drop  = ~clear_i & sample_i & ~w_push;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
      r_drop   <= '0;
    end else if (clear_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_usage  <= '0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_usage <= r_usage + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= w_entry_bits;
  end

  // Head is masked so stale storage never shows while empty or in reset.
  assign fifo_if.data_o  = w_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_if.valid_o = w_valid;
  assign fifo_if.full_o  = w_full;
  assign drop_cnt_o      = r_drop;

endmodule

// File: doc/multi_counter_fifo.md
MULTI_COUNTER_FIFO -- requirements
Module: multi_counter_fifo

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent counter channels, 1..16.
REQ-002 SHALL have parameter WIDTH, default 8: counter, delta and load-data width, 2..32.
REQ-003 SHALL have parameter DEPTH, default 4: sample FIFO entries, power of two, 2 or more.
REQ-004 SHALL define CH_W = max(1, clog2(NUM_CH)) and sample entry width SW = CH_W + WIDTH.
REQ-005 clk_i  in  1  sole clock; all state changes on its rising edge.
REQ-006 rst_ni  in  1  asynchronous, active-low reset.
REQ-007 clear_i  in  1  synchronous clear of all counters, maxima, flags, FIFO and drop count.
REQ-008 en_i  in  NUM_CH  per-channel count enable.
REQ-009 down_i  in  NUM_CH  per-channel direction: 1 = subtract, 0 = add.
REQ-010 delta_i  in  WIDTH  step applied to every enabled channel.
REQ-011 load_i  in  1  load d_i into channel load_ch_i.
REQ-012 load_ch_i  in  CH_W  load target channel.
REQ-013 d_i  in  WIDTH  load value.
REQ-014 rd_ch_i  in  CH_W  channel observed on q_o and max_o.
REQ-015 q_o / max_o  out  WIDTH each  registered count / running maximum of rd_ch_i (combinational select).
REQ-016 overflow_o  out  NUM_CH  sticky wrap flag per channel.
REQ-017 sample_i / sample_ch_i  in  1 / CH_W  request to snapshot a channel into the FIFO.
REQ-018 data_o  out  SW  FIFO head: {channel[CH_W-1:0], count[WIDTH-1:0]}.
REQ-019 valid_o / ready_i  out / in  1 each  FIFO output handshake; an entry pops when both are 1.
REQ-020 full_o  out  1  FIFO holds DEPTH entries.
REQ-021 drop_cnt_o  out  WIDTH  saturating count of lost samples.

Function
REQ-022 Counter update: add mode gives cnt + delta mod 2^WIDTH; a carry-out sets that channel's overflow bit.
REQ-023 Counter update: subtract mode gives cnt - delta mod 2^WIDTH; a borrow sets that channel's overflow bit.
REQ-024 Per-channel priority, highest first: clear_i, then load (channel matches load_ch_i), then en_i.
REQ-025 A load SHALL NOT change overflow_o.
REQ-026 max register: after each update, max <= new count if new count > max (unsigned); this includes loads.
REQ-027 A wrap SHALL NOT reduce max.
REQ-028 A sample captures the pre-update registered count of sample_ch_i, so a same-cycle en/load is not included.
REQ-029 FIFO is not fall-through: an entry pushed into an empty FIFO gives valid_o = 1 on the following cycle.
REQ-030 Entries leave in push order.
REQ-031 valid_o = not empty; data_o is stable while valid_o = 1 and ready_i = 0.
REQ-032 Push while full is accepted only if a pop occurs in the same cycle; otherwise the sample is dropped and drop_cnt_o increments, saturating at 2^WIDTH-1.
REQ-033 An out-of-range channel index (>= NUM_CH) is ignored: a load has no effect, a sample is not pushed and counts as dropped, and q_o/max_o read 0.
REQ-034 clear_i zeroes counters, maxima, overflow_o and drop_cnt_o, and empties the FIFO (valid_o = 0 next cycle).
REQ-035 A sample_i, load_i or pop in the same cycle as clear_i is discarded.

Reset
REQ-036 While rst_ni = 0, all counters, maxima, overflow_o, drop_cnt_o and FIFO pointers/usage are 0.
REQ-037 Output values during reset: valid_o = 0, full_o = 0, data_o = 0.
REQ-038 Reset asserted mid-operation discards all FIFO contents immediately and asynchronously.

Structure
REQ-039 A shared package multi_counter_pkg SHALL hold the CH_W function and the sample entry struct {ch, count}.
REQ-040 The per-channel counter plus max plus overflow logic SHALL be one sub-module, mc_channel, generated NUM_CH times.
REQ-041 The FIFO SHALL be inline storage with read/write pointers and a usage counter of clog2(DEPTH)+1 bits.

Verification
REQ-042 Wrap: ch0 = 250, en, delta = 10, add -> next cycle ch0 = 4, overflow_o[0] = 1, max stays 250.
REQ-043 Priority: load ch1 d = 100 together with en[1], delta = 5 -> ch1 = 100; load d = 20 later -> max stays 100.
REQ-044 Sample and pop: sample ch2 = 7 into an empty FIFO -> valid_o = 1 one cycle later, data_o = {2, 7}; ready_i = 1 -> valid_o = 0 after the pop.
REQ-045 Overflow of FIFO: DEPTH = 4, ready_i = 0, six samples -> full_o = 1, drop_cnt_o = 2; push with simultaneous pop when full -> accepted, drop_cnt_o unchanged.
REQ-046 Clear: assert clear_i with a pending sample and 3 queued entries -> next cycle valid_o = 0 and all counters, maxima, overflow_o and drop_cnt_o = 0.
REQ-047 Async reset: pull rst_ni low between clock edges with the FIFO full -> all outputs 0 immediately, with no clock edge needed.
